// File: rtl/arm_verilog.sv
// Two-wire serial transmitter: start, 7 address bits, 8 data bits (MSB first), stop.
// Outputs are registered and always driven; the line idles at OutD=1, OutC=1.
//
//   state   | meaning
//   IDLE    | line idle (1/1), waiting for Go
//   START   | start condition: OutD low while OutC high
//   BIT_LO  | OutC low, OutD presents the current bit
//   BIT_HI  | OutC high, OutD holds the current bit
//   STOP_LO | OutC low, OutD low ahead of the stop
//   STOP_HI | OutC high, OutD low; rises to idle on the next edge
module arm_verilog (
    output logic       OutD,
    output logic       OutC,
    input  logic [7:0] D,
    input  logic [6:0] A,
    input  logic       Go,
    input  logic       clk_in,
    input  logic       reset_n
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT_LO,
        BIT_HI,
        STOP_LO,
        STOP_HI
    } state_t;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [14:0] shift_reg;

    // Outputs are assigned alongside the transition so they reflect the state being entered.
    always_ff @(posedge clk_in) begin
        if (reset_n) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shift_reg <= 15'd0;
            OutD      <= 1'b1;
            OutC      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (Go) begin
                        shift_reg <= {A, D};
                        bit_cnt   <= 4'd0;
                        state     <= START;
                        OutD      <= 1'b0;
                        OutC      <= 1'b1;
                    end
                end
                START: begin
                    state <= BIT_LO;
                    OutC  <= 1'b0;
                    OutD  <= shift_reg[14];
                end
                BIT_LO: begin
                    state <= BIT_HI;
                    OutC  <= 1'b1;
                end
                BIT_HI: begin
                    OutC <= 1'b0;
                    if (bit_cnt == 4'd14) begin
                        state <= STOP_LO;
                        OutD  <= 1'b0;
                    end else begin
                        state     <= BIT_LO;
                        bit_cnt   <= bit_cnt + 4'd1;
                        shift_reg <= {shift_reg[13:0], 1'b0};
                        OutD      <= shift_reg[13];
                    end
                end
                STOP_LO: begin
                    state <= STOP_HI;
                    OutC  <= 1'b1;
                    OutD  <= 1'b0;
                end
                STOP_HI: begin
                    state   <= IDLE;
                    bit_cnt <= 4'd0;
                    OutC    <= 1'b1;
                    OutD    <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    OutC  <= 1'b1;
                    OutD  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_verilog.sv
// Directed bench for arm_verilog: per-cycle waveform checks against hand-computed
// frame contents, plus reset, back-to-back and Go-ignore sequences.
module tb_arm_verilog;

    logic       OutD, OutC;
    logic [7:0] D;
    logic [6:0] A;
    logic       Go;
    logic       clk_in;
    logic       reset_n;

    int n_tests = 0;
    int n_fail  = 0;

    arm_verilog dut (
        .OutD    (OutD),
        .OutC    (OutC),
        .D       (D),
        .A       (A),
        .Go      (Go),
        .clk_in  (clk_in),
        .reset_n (reset_n)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [6:0]  a;
        logic [7:0]  d;
        logic [14:0] exp_bits;
        logic        pulses;
        logic        hold;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Expected {OutD, OutC} for frame cycle n (1..34) carrying the 15 bits b.
    function automatic logic [1:0] exp_line(input int n, input logic [14:0] b);
        int k;
        if (n == 1) return 2'b01;
        if (n <= 31) begin
            k = (n - 2) / 2;
            return {b[14 - k], logic'(n % 2 == 1)};
        end
        if (n == 32) return 2'b00;
        if (n == 33) return 2'b01;
        return 2'b11;
    endfunction

    // Called in an idle cycle (or cycle 34 of a held frame); returns after cycle 34 is sampled.
    task automatic run_frame(input vec_t v, input string tag);
        logic [14:0] got_bits;
        int          rises;
        int          bad_stable;
        logic        prev_d, prev_c;
        got_bits   = '0;
        rises      = 0;
        bad_stable = 0;
        A  = v.a;
        D  = v.d;
        Go = 1'b1;
        tick();
        A  = ~v.a;
        D  = ~v.d;
        Go = v.hold;
        for (int n = 1; n <= 34; n++) begin
            if (n > 1) tick();
            Go = v.hold;
            if (v.pulses && (n == 5 || n == 20)) Go = 1'b1;
            check($sformatf("%s cyc%0d line", tag, n), {30'd0, OutD, OutC},
                  {30'd0, exp_line(n, v.exp_bits)});
            if (n > 1) begin
                if (prev_c && OutC && (OutD !== prev_d) && n != 34) bad_stable++;
                if (!prev_c && OutC && n <= 31) begin
                    got_bits = {got_bits[13:0], OutD};
                    rises++;
                end
            end
            prev_d = OutD;
            prev_c = OutC;
        end
        check({tag, " bits"}, {17'd0, got_bits}, {17'd0, v.exp_bits});
        check({tag, " rises"}, rises, 15);
        check({tag, " stable"}, bad_stable, 0);
    endtask

    initial begin
        vecs[0] = '{7'h7F, 8'hFF, 15'b111111111111111, 1'b0, 1'b0};
        vecs[1] = '{7'h55, 8'hA3, 15'b101010110100011, 1'b0, 1'b0};
        vecs[2] = '{7'h55, 8'hA3, 15'b101010110100011, 1'b1, 1'b1};
        vecs[3] = '{7'h2A, 8'h5C, 15'b010101001011100, 1'b0, 1'b0};
        vecs[4] = '{7'h01, 8'h80, 15'b000000110000000, 1'b0, 1'b0};
        vecs[5] = '{7'h40, 8'h01, 15'b100000000000001, 1'b0, 1'b0};
        vecs[6] = '{7'h00, 8'h00, 15'b000000000000000, 1'b0, 1'b0};

        A = '0;
        D = '0;
        Go = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;

        // Idle line with Go low
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 50; i++) begin
                if (OutD !== 1'b1 || OutC !== 1'b1) bad++;
                tick();
            end
            check("idle 50 cycles", bad, 0);
        end

        // Table frames; vecs[2] holds Go so vecs[3] starts at cycle 35
        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
            if (!vecs[i].hold) begin
                Go = 1'b0;
                tick();
                check($sformatf("vec%0d idle after", i), {30'd0, OutD, OutC}, 32'd3);
            end
        end

        // Reset at cycle 12 aborts the frame
        A  = 7'h55;
        D  = 8'hA3;
        Go = 1'b1;
        tick();
        Go = 1'b0;
        A  = 7'h00;
        for (int n = 2; n <= 12; n++) tick();
        check("pre-abort cyc12 line", {30'd0, OutD, OutC}, {30'd0, exp_line(12, 15'b101010110100011)});
        reset_n = 1'b1;
        Go = 1'b1;
        tick();
        check("abort cyc13 line", {30'd0, OutD, OutC}, 32'd3);
        tick();
        check("reset beats Go", {30'd0, OutD, OutC}, 32'd3);
        reset_n = 1'b0;
        Go = 1'b0;
        tick();
        tick();
        check("idle after release", {30'd0, OutD, OutC}, 32'd3);

        // Go at first non-reset edge is honoured
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        run_frame(vecs[3], "post-reset");
        Go = 1'b0;
        tick();
        check("final idle", {30'd0, OutD, OutC}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arm_verilog.md
ARM_VERILOG -- requirements
Module: arm_verilog

Interface
REQ-001 Ports: no parameters; all widths fixed.
REQ-002 clk_in  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-high (asserted when reset_n=1), sampled on rising clk_in.
REQ-004 D  input  8  data byte to transmit, sampled only when a frame is accepted.
REQ-005 A  input  7  address to transmit, sampled only when a frame is accepted.
REQ-006 Go  input  1  frame request, level-sampled each rising edge.
REQ-007 OutD  output  1  serial data line, registered.
REQ-008 OutC  output  1  serial clock line, registered.
REQ-009 Port order on instantiation: OutD, OutC, D, A, Go, clk_in, reset_n.

Function
REQ-010 The block SHALL be a two-wire serial transmitter: start condition, 7 address bits, 8 data bits, stop condition; idle line state OutD=1, OutC=1.
REQ-011 States SHALL be IDLE, START, BIT_LO, BIT_HI, STOP_LO, STOP_HI; a 4-bit bit counter (0..14) and a 15-bit shift register {A,D} SHALL be kept.
REQ-012 In IDLE, Go=1 at a rising edge (edge E0) SHALL latch {A[6:0],D[7:0]} into the shift register and enter START; Go=0 keeps IDLE.
REQ-013 Cycle numbering: cycle n is the clk_in period following edge E0+n-1 (cycle 1 follows E0).
REQ-014 Cycle 1 (START): OutD=0, OutC=1.
REQ-015 For bit k=0..14, transmitted MSB first (k=0 is A[6], k=6 is A[0], k=7 is D[7], k=14 is D[0]): cycle 2k+2 (BIT_LO) OutC=0, OutD=bit k; cycle 2k+3 (BIT_HI) OutC=1, OutD=bit k unchanged.
REQ-016 OutD SHALL change only while OutC=0, except in the start and stop conditions.
REQ-017 Cycle 32 (STOP_LO): OutC=0, OutD=0; cycle 33 (STOP_HI): OutC=1, OutD=0; edge ending cycle 33 returns to IDLE, so cycle 34 shows OutD=1, OutC=1.
REQ-018 Frame length SHALL be 33 cycles from E0 to the first idle cycle; the edge ending cycle 34 is the earliest at which a new Go SHALL be accepted (back-to-back frames separated by one idle cycle).
REQ-019 Go SHALL be ignored in every non-IDLE state; changes of A and D after E0 SHALL NOT affect the frame in progress.
REQ-020 Go held high continuously SHALL start a new frame every 34 cycles, each with A/D sampled at its own accept edge.
REQ-021 No error, abort or acknowledge behaviour exists; OutC and OutD are always driven (push-pull).

Reset
REQ-022 While reset is asserted at a rising edge: state=IDLE, counter=0, shift register=0, OutD=1, OutC=1 from the next cycle.
REQ-023 Reset SHALL take priority over Go and SHALL abort any frame in progress immediately (no stop condition generated).
REQ-024 Reset release SHALL NOT start a frame by itself; Go sampled at the first non-reset edge SHALL be honoured.

Verification
REQ-025 Reset asserted 2 cycles, Go=0 -> OutD=1, OutC=1 constantly for 50 cycles.
REQ-026 A=7'h7F, D=8'hFF, Go=1 for one cycle then A=0, D=0, Go=0 -> cycle1 OutD=0/OutC=1; cycles 2-31 OutD=1 with OutC toggling 0,1; cycles 32-33 OutD=0 with OutC=0,1; cycle 34 idle 1/1.
REQ-027 A=7'h55, D=8'hA3, one Go pulse -> OutD sampled at each OutC rising edge yields 1010101 then 10100011; exactly 15 OutC rising edges between start and stop.
REQ-028 Go pulsed again at cycles 5 and 20 of a frame -> ignored; frame identical to REQ-027; then Go held high -> second frame begins at cycle 35 start condition.
REQ-029 Reset asserted at cycle 12 of a frame -> next cycle OutD=1, OutC=1, state IDLE; subsequent Go starts a complete fresh frame.
REQ-030 Bench SHALL check every cycle that OutD never changes while OutC=1 other than at start (cycle 1) and stop (cycle 34).
